// File: rtl/hourglass_ctrl.sv
// Countdown controller for the electronic hourglass: preset, run, pause, expiry, alarm.
// Ports: clk, rst, tick, key_start/up/down/clr in; preset, remain, running, done, beep out.
// Optional HOURGLASS_FLIP_EN adds the key_up "turn the hourglass over" action.
module hourglass_ctrl #(
  parameter int TIME_W     = 7,
  parameter int MAX_SEC    = 99,
  parameter int DEF_SEC    = 30,
  parameter int BEEP_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              key_start,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_clr,
  output logic [TIME_W-1:0] preset,
  output logic [TIME_W-1:0] remain,
  output logic              running,
  output logic              done,
  output logic              beep
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_SEC);
  localparam logic [TIME_W-1:0] DEF_V = TIME_W'(DEF_SEC);
  localparam logic [TIME_W-1:0] ONE   = TIME_W'(1);
  localparam logic [3:0]        BT    = 4'(BEEP_TICKS);

  state_t            state, state_n;
  logic [TIME_W-1:0] preset_n, remain_n;
  logic [3:0]        cnt, cnt_n;
  logic              beep_n;
  logic              adj_up, adj_dn;

  // Simultaneous up and down cancel each other.
  assign adj_up = key_up & ~key_down;
  assign adj_dn = key_down & ~key_up;

`ifdef HOURGLASS_FLIP_EN
  logic [TIME_W-1:0] flip_val;
  assign flip_val = preset - remain;
`endif

  always_comb begin
    state_n  = state;
    preset_n = preset;
    remain_n = remain;
    cnt_n    = cnt;
    beep_n   = beep;
    if (key_clr) begin
      state_n  = IDLE;
      remain_n = preset;
      beep_n   = 1'b0;
      cnt_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_start) begin
            if (preset != '0) state_n = RUN;
          end else if (adj_up) begin
            preset_n = (preset == MAX_V) ? '0 : preset + ONE;
            remain_n = preset_n;
          end else if (adj_dn) begin
            preset_n = (preset == '0) ? MAX_V : preset - ONE;
            remain_n = preset_n;
          end
        end
        RUN: begin
          if (key_start) begin
            state_n = PAUSE;
`ifdef HOURGLASS_FLIP_EN
          end else if (adj_up) begin
            remain_n = flip_val;
            if (flip_val == '0) begin
              state_n = DONE;
              beep_n  = 1'b1;
              cnt_n   = '0;
            end
`endif
          end else if (tick) begin
            // remain <= 1 also guards against ever wrapping below zero.
            if (remain <= ONE) begin
              remain_n = '0;
              state_n  = DONE;
              beep_n   = 1'b1;
              cnt_n    = '0;
            end else begin
              remain_n = remain - ONE;
            end
          end
        end
        PAUSE: begin
          if (key_start) begin
            state_n = RUN;
`ifdef HOURGLASS_FLIP_EN
          end else if (adj_up) begin
            remain_n = flip_val;
            if (flip_val == '0) begin
              state_n = DONE;
              beep_n  = 1'b1;
              cnt_n   = '0;
            end
`endif
          end
        end
        DONE: begin
          if (key_start) begin
            state_n  = RUN;
            remain_n = preset;
            beep_n   = 1'b0;
            cnt_n    = '0;
          end else if (tick && cnt < BT) begin
            // Counter saturates at BEEP_TICKS so beep stays low afterwards.
            cnt_n = cnt + 4'd1;
            if (cnt_n == BT) beep_n = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      preset  <= DEF_V;
      remain  <= DEF_V;
      cnt     <= '0;
      beep    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      preset  <= preset_n;
      remain  <= remain_n;
      cnt     <= cnt_n;
      beep    <= beep_n;
      running <= (state_n == RUN);
      done    <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_hourglass_ctrl.sv
// Directed bench for hourglass_ctrl with hand-computed expectations.
// Ports: drives all DUT inputs, samples outputs 1 time unit after each rising edge.
module tb_hourglass_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, key_start, key_up, key_down, key_clr;
  logic [6:0] preset, remain;
  logic       running, done, beep;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hourglass_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .key_start(key_start), .key_up(key_up),
    .key_down(key_down), .key_clr(key_clr),
    .preset(preset), .remain(remain),
    .running(running), .done(done), .beep(beep)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; outputs sampled #1 after the edge.
  task automatic step(input logic c, input logic s, input logic u,
                      input logic d, input logic t);
    @(negedge clk);
    key_clr = c; key_start = s; key_up = u; key_down = d; tick = t;
    @(posedge clk);
    #1;
    key_clr = 0; key_start = 0; key_up = 0; key_down = 0; tick = 0;
  endtask

  task automatic flags(input string tag, input int r, input int d, input int b);
    chk({tag, ".running"}, int'(running), r);
    chk({tag, ".done"}, int'(done), d);
    chk({tag, ".beep"}, int'(beep), b);
  endtask

  initial begin
    rst = 1; tick = 0; key_start = 0; key_up = 0; key_down = 0; key_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.preset", int'(preset), 30);
    chk("rst.remain", int'(remain), 30);
    flags("rst", 0, 0, 0);
    @(negedge clk); rst = 0;

    // 3 up, 1 down, start
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("adj.preset", int'(preset), 32);
    chk("adj.remain", int'(remain), 32);
    step(0, 1, 0, 0, 0);
    chk("start.running", int'(running), 1);
    chk("start.remain", int'(remain), 32);
    step(0, 0, 1, 0, 0);
    chk("run_up.preset", int'(preset), 32);
    step(0, 0, 1, 1, 0);
    chk("run_updn.remain", int'(remain), 32);

    // wrap checks
    step(1, 0, 0, 0, 0);
    flags("clr1", 0, 0, 0);
    repeat (32) step(0, 0, 0, 1, 0);
    chk("dn_to0.preset", int'(preset), 0);
    step(0, 0, 0, 1, 0);
    chk("wrap_dn.preset", int'(preset), 99);
    step(0, 0, 1, 1, 0);
    chk("both.preset", int'(preset), 99);
    step(0, 0, 1, 0, 0);
    chk("wrap_up.preset", int'(preset), 0);
    chk("wrap_up.remain", int'(remain), 0);
    step(0, 1, 0, 0, 0);
    flags("start0", 0, 0, 0);

    // expiry and beep
    repeat (2) step(0, 0, 1, 0, 0);
    chk("p2.preset", int'(preset), 2);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t1.remain", int'(remain), 1);
    flags("t1", 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t2.remain", int'(remain), 0);
    flags("t2", 0, 1, 1);
    step(0, 0, 0, 0, 0);
    flags("t2idle", 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    flags("bt2", 0, 1, 1);
    step(0, 0, 1, 0, 1);
    flags("bt3", 0, 1, 0);
    chk("bt3.preset", int'(preset), 2);
    step(0, 0, 0, 0, 1);
    flags("bt4", 0, 1, 0);
    chk("bt4.remain", int'(remain), 0);

    // restart from DONE, expire, clear mid-beep
    step(0, 1, 0, 0, 0);
    chk("restart.remain", int'(remain), 2);
    flags("restart", 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    flags("exp2", 0, 1, 1);
    step(1, 1, 0, 0, 1);
    flags("clr_beep", 0, 0, 0);
    chk("clr_beep.remain", int'(remain), 2);

    // pause behaviour at remain 10
    repeat (8) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("r10.remain", int'(remain), 10);
    step(0, 1, 0, 0, 1);
    chk("pause.remain", int'(remain), 10);
    flags("pause", 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("pause_tick.remain", int'(remain), 10);
    step(0, 0, 0, 1, 0);
    chk("pause_dn.preset", int'(preset), 10);
    step(0, 1, 0, 0, 0);
    chk("resume.running", int'(running), 1);
    chk("resume.remain", int'(remain), 10);
    step(0, 0, 0, 0, 1);
    chk("resume_tick.remain", int'(remain), 9);

    // flip at preset 20, remain 5
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    chk("p20.preset", int'(preset), 20);
    step(0, 1, 0, 0, 0);
    repeat (15) step(0, 0, 0, 0, 1);
    chk("r5.remain", int'(remain), 5);
    step(0, 0, 0, 1, 0);
    chk("run_dn.remain", int'(remain), 5);
    step(0, 0, 1, 0, 0);
`ifdef HOURGLASS_FLIP_EN
    chk("flip.remain", int'(remain), 15);
`else
    chk("flip.remain", int'(remain), 5);
`endif
    chk("flip.running", int'(running), 1);

    // reset mid-RUN
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rst2.preset", int'(preset), 30);
    chk("rst2.remain", int'(remain), 30);
    flags("rst2", 0, 0, 0);
    @(negedge clk); rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hourglass_ctrl.md
# hourglass_ctrl

Countdown controller for the electronic hourglass. Consumes the one-cycle key pulses produced by the per-key debouncers plus a 1 Hz tick strobe, and sequences the countdown: preset adjustment, run, pause, expiry and alarm. All outputs are registered and drive the display and buzzer logic directly.

## Interface
- `TIME_W`, 7: width of the preset and remaining-time values, in seconds.
- `MAX_SEC`, 99: largest settable preset; must be < 2^TIME_W.
- `DEF_SEC`, 30: preset loaded at reset; must be ≤ MAX_SEC.
- `BEEP_TICKS`, 3: number of ticks `beep` stays high after expiry, 1..15.

Ports (clock and reset first):
- `clk` in 1: system clock; all logic runs on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `tick` in 1: one-cycle strobe, once per second.
- `key_start` in 1: debounced pulse that toggles start/pause.
- `key_up` in 1: debounced pulse that increments the preset.
- `key_down` in 1: debounced pulse that decrements the preset.
- `key_clr` in 1: debounced pulse that aborts the countdown and reloads the preset.
- `preset` out TIME_W: current preset, in seconds.
- `remain` out TIME_W: seconds remaining.
- `running` out 1: high in the RUN state.
- `done` out 1: high in the DONE state.
- `beep` out 1: alarm drive.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Key priority within one cycle: `key_clr` > `key_start` > `key_up`/`key_down`.
- `key_up` and `key_down` in the same cycle: both are ignored.
- `key_clr` in any state:
  - go to IDLE;
  - `remain` <= `preset`;
  - `beep` <= 0; beep counter cleared.
- IDLE:
  - `key_up`: `preset` +1, wrapping MAX_SEC→0.
  - `key_down`: `preset` −1, wrapping 0→MAX_SEC.
  - `remain` follows the new `preset` in the same update.
  - `key_start` with `preset` ≠ 0: go to RUN.
  - `key_start` with `preset` == 0: ignored.
- RUN:
  - `tick`: `remain` −1.
  - `tick` with `remain` == 1: `remain` <= 0 and go to DONE.
  - `key_start`: go to PAUSE. A `tick` in the same cycle is discarded; no decrement.
  - `key_down`: ignored.
  - `key_up`: ignored unless HOURGLASS_FLIP_EN is defined.
- PAUSE:
  - `tick`, `key_up` and `key_down` are ignored.
  - `key_start`: return to RUN with `remain` unchanged.
- DONE:
  - On entry: `beep` = 1, beep counter = 0.
  - Each `tick` increments the counter.
  - When the counter reaches BEEP_TICKS, `beep` <= 0.
  - `key_start`: reload `remain` <= `preset`, `beep` <= 0, go to RUN.
  - `key_up` and `key_down`: ignored.
- `preset` changes only in IDLE. `remain` never underflows.

## Timing
- Reset values: `preset` = DEF_SEC, `remain` = DEF_SEC, `running` = 0, `done` = 0, `beep` = 0.
- Latency:
  - An input pulse in cycle N is reflected on every output in cycle N+1.
  - No combinational path from any input to any output.
- `running`, `done` and `beep` are decoded from the next-state value and registered, so they change in the same cycle as the state.
- Expiry: a `tick` in cycle N with `remain` = 1 gives `remain` = 0, `done` = 1, `running` = 0 and `beep` = 1 in cycle N+1.
- With BEEP_TICKS = B, `beep` falls in the cycle after the B-th `tick` following DONE entry.
- Reset during any state, including mid-beep, returns all outputs to their reset values on the next edge.
- Input pulses wider than one cycle are not supported. Each cycle a pulse is high counts as a separate event.

## Configuration
- `HOURGLASS_FLIP_EN` defined:
  - `key_up` in RUN or PAUSE turns the hourglass over: `remain` <= `preset` − `remain`; the state is unchanged.
  - If the result is 0, go to DONE, with the normal DONE entry behaviour.
  - Flip has lower priority than `key_start` in the same cycle.
- `HOURGLASS_FLIP_EN` not defined: `key_up` in RUN or PAUSE is ignored. No flip logic is synthesized.

## Test plan
- Reset, then 3 × `key_up`, 1 × `key_down`, 1 × `key_start` → `preset` = 32, `remain` = 32, `running` = 1 one cycle after the start pulse.
- IDLE at `preset` = 99, `key_up` → `preset` = 0. Then `key_start` → state stays IDLE, `running` = 0.
- `preset` = 2, start, then 2 ticks → `remain` 1 then 0; `done` = 1 and `beep` = 1 in the cycle after the 2nd tick. After 3 more ticks `beep` = 0 and `done` stays 1.
- RUN at `remain` = 10, with `key_start` and `tick` in the same cycle → PAUSE, `remain` = 10. A further `tick` → still 10. `key_start` → RUN.
- During DONE with `beep` = 1, assert `key_clr` → IDLE, `remain` = `preset`, `beep` = 0. Assert `rst` mid-RUN → `preset` = `remain` = 30, all flags 0.
- With HOURGLASS_FLIP_EN, `preset` = 20 and `remain` = 5 in RUN, `key_up` → `remain` = 15, still RUN. Without the macro → `remain` = 5.
